multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
// PURPOSE
// - Parametrised successor of the single-cycle combinational ALU: registered integer ALU adding iterative
//   unsigned multiply and divide behind a valid/ready handshake.
// - Sits between operand fetch and writeback of the multi-cycle datapath; one operation in flight at a time.
// PARAMETERS
// - WIDTH    32  operand/result width; >=8, power of two
// - FUNCT_W  6   width of Funct opcode
// PORTS
// - clk        in   1        single clock, rising edge
// - rst_n      in   1        asynchronous, active-low reset
// - in_valid   in   1        Src1/Src2/Funct valid this cycle
// - in_ready   out  1        block accepts an operation this cycle
// - Src1       in   WIDTH    operand A
// - Src2       in   WIDTH    operand B; shifts use Src2[$clog2(WIDTH)-1:0]
// - Funct      in   FUNCT_W  opcode
// - out_valid  out  1        result outputs valid
// - out_ready  in   1        consumer takes result this cycle
// - ALU_result out  WIDTH    result / product low half / quotient
// - ALU_hi     out  WIDTH    product high half / remainder; 0 for other ops
// - ALU_Carry  out  1        ADD: carry-out; SUB: carry-out of A+~B+1 (1 = no borrow); else 0
// - Div_zero   out  1        DIVU with Src2==0
// - Illegal    out  1        unknown Funct
// BEHAVIOUR
// - Funct: ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100, NOR 000101, SLT 000110 (signed),
//   SLTU 000111, SLL 001000, SRL 001001, SRA 001010, MULTU 011000, DIVU 011010; any other code is illegal.
// - Reset: state IDLE; in_ready=1 only after rst_n deasserts; out_valid=0; all result/flag outputs 0.
// - FSM IDLE -> (accept, simple/illegal op) DONE; IDLE -> (accept MULTU) MUL; -> (accept DIVU) DIV;
//   MUL/DIV -> DONE after WIDTH steps; DONE -> (out_ready) IDLE, or straight into the next op on a same-cycle accept.
// - Accept = in_valid & in_ready at an edge k; operands and Funct are latched at that edge.
// - in_ready = (state==IDLE) | (state==DONE & out_ready); no other state accepts.
// - Simple ops: result registered at edge k; out_valid high after k (latency 1).
// - MULTU: shift-add, one bit per edge k+1..k+WIDTH; out_valid after edge k+WIDTH; {ALU_hi,ALU_result}=A*B.
// - DIVU: restoring, one bit per edge k+1..k+WIDTH; same latency; quotient in ALU_result, remainder in ALU_hi.
// - DIVU by 0: still WIDTH cycles; ALU_result=all ones, ALU_hi=Src1, Div_zero=1.
// - Illegal: latency 1; ALU_result=0, ALU_hi=0, Illegal=1; no other flag set.
// - Arithmetic modulo 2^WIDTH; SLT/SLTU give 0/1 zero-extended; SRA sign-fills.
// - Flags cleared on every accept; valid only while out_valid=1.
// - Outputs held stable while out_valid & !out_ready; out_valid drops after the edge that sees out_ready,
//   unless a new op is accepted at that edge.
// - Same-edge handoff: a simple op accepted in DONE gives out_valid high on the next cycle, with the new result.
// - in_valid while busy is ignored (not latched); the source holds it per handshake.
// - rst_n low mid-MUL/DIV: in-flight op discarded, all state cleared asynchronously; no output after release.
// STRUCTURE
// - Package alu_pkg: Funct localparams, FSM state encoding (IDLE/MUL/DIV/DONE), is_muldiv(funct) function.
// - Sub-module alu_iter_muldiv: shared WIDTH-step shift register/adder for MULTU and DIVU; start/done pulse,
//   step counter of width $clog2(WIDTH)+1.
// - Top: handshake FSM, combinational simple-op unit, output registers.
// TESTING (WIDTH=32)
// - ADD 0xFFFF_FFFF + 0x1 -> out_valid 1 cycle after accept, result 0x0, Carry 1; SUB 0x10-0x20 -> 0xFFFF_FFF0, Carry 0.
// - MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> out_valid exactly 32 cycles after accept, hi 0xFFFF_FFFE, lo 0x0000_0001.
// - DIVU 0x1800/0x200 -> quotient 0xC, remainder 0x0; DIVU 7/0 -> result 0xFFFF_FFFF, hi 0x7, Div_zero 1.
// - Backpressure: out_ready=0 for 5 cycles after SLT -> outputs stable, in_ready 0; then out_ready=1 with a
//   new in_valid -> accepted on the same edge.
// - rst_n pulsed low at cycle 10 of a MULTU -> out_valid 0, outputs 0 immediately, no result after release.
// - Funct 111111 -> Illegal 1, result 0, latency 1; SRA 0x8000_0000 by 4 -> 0xF800_0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, handshake FSM encoding and opcode classification for multicycle_alu.
package alu_pkg;

  localparam logic [5:0] F_ADD   = 6'b000000;
  localparam logic [5:0] F_SUB   = 6'b000001;
  localparam logic [5:0] F_AND   = 6'b000010;
  localparam logic [5:0] F_OR    = 6'b000011;
  localparam logic [5:0] F_XOR   = 6'b000100;
  localparam logic [5:0] F_NOR   = 6'b000101;
  localparam logic [5:0] F_SLT   = 6'b000110;
  localparam logic [5:0] F_SLTU  = 6'b000111;
  localparam logic [5:0] F_SLL   = 6'b001000;
  localparam logic [5:0] F_SRL   = 6'b001001;
  localparam logic [5:0] F_SRA   = 6'b001010;
  localparam logic [5:0] F_MULTU = 6'b011000;
  localparam logic [5:0] F_DIVU  = 6'b011010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one WIDTH-step datapath.
// res_hi/res_lo carry the values written on the final step so the caller can register them on that edge.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mq, opb;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;
  logic [WIDTH:0]   sum, shifted, diff;

  // acc holds the product high half / partial remainder, mq the multiplier / quotient
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, opb};
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    acc_nxt = acc;
    mq_nxt  = mq;
    if (div_q) begin
      if (shifted >= {1'b0, opb}) begin
        acc_nxt = diff[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else if (mq[0]) begin
      {acc_nxt, mq_nxt} = {sum, mq[WIDTH-1:1]};
    end else begin
      {acc_nxt, mq_nxt} = {1'b0, acc, mq[WIDTH-1:1]};
    end
  end

  assign done   = busy && (cnt == CW'(1));
  assign res_hi = acc_nxt;
  assign res_lo = mq_nxt;

  // A zero divisor needs no special case: every step subtracts, so the quotient fills with ones
  // and the dividend shifts whole into the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      opb   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= div_mode;
      cnt   <= CW'(WIDTH);
      acc   <= '0;
      mq    <= a;
      opb   <= b;
    end else if (busy) begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered integer ALU with iterative MULTU/DIVU behind a valid/ready handshake;
// one operation in flight, results held until the consumer takes them.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   Src1,
  input  logic [WIDTH-1:0]   Src2,
  input  logic [FUNCT_W-1:0] Funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   ALU_result,
  output logic [WIDTH-1:0]   ALU_hi,
  output logic               ALU_Carry,
  output logic               Div_zero,
  output logic               Illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state, state_next;
  logic               accept, md_start, md_done;
  logic [WIDTH-1:0]   md_hi, md_lo;
  logic [WIDTH-1:0]   simple_res;
  logic               simple_carry, illegal_op, muldiv_op, multu_op;
  logic               b_zero_q;
  logic [SHW-1:0]     shamt;

  assign shamt = Src2[SHW-1:0];

  always_comb begin
    simple_res   = '0;
    simple_carry = 1'b0;
    illegal_op   = 1'b0;
    multu_op     = 1'b0;
    case (Funct)
      FUNCT_W'(F_ADD):   {simple_carry, simple_res} = {1'b0, Src1} + {1'b0, Src2};
      FUNCT_W'(F_SUB):   {simple_carry, simple_res} = {1'b0, Src1} + {1'b0, ~Src2} + (WIDTH+1)'(1);
      FUNCT_W'(F_AND):   simple_res = Src1 & Src2;
      FUNCT_W'(F_OR):    simple_res = Src1 | Src2;
      FUNCT_W'(F_XOR):   simple_res = Src1 ^ Src2;
      FUNCT_W'(F_NOR):   simple_res = ~(Src1 | Src2);
      FUNCT_W'(F_SLT):   simple_res = WIDTH'($signed(Src1) < $signed(Src2));
      FUNCT_W'(F_SLTU):  simple_res = WIDTH'(Src1 < Src2);
      FUNCT_W'(F_SLL):   simple_res = Src1 << shamt;
      FUNCT_W'(F_SRL):   simple_res = Src1 >> shamt;
      FUNCT_W'(F_SRA):   simple_res = $unsigned($signed(Src1) >>> shamt);
      FUNCT_W'(F_MULTU): multu_op = 1'b1;
      FUNCT_W'(F_DIVU):  multu_op = 1'b0;
      default:           illegal_op = 1'b1;
    endcase
  end

  // Only a code that matched the decode above reaches is_muldiv, so narrowing Funct is safe
  assign muldiv_op = !illegal_op && is_muldiv(6'(Funct));
  assign in_ready  = rst_n && ((state == IDLE) || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && muldiv_op;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (!muldiv_op)    state_next = DONE;
          else if (multu_op) state_next = MUL;
          else               state_next = DIV;
        end else if (state == DONE && out_ready) begin
          state_next = IDLE;
        end
      end
      MUL, DIV: if (md_done) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .div_mode (!multu_op),
    .a        (Src1),
    .b        (Src2),
    .done     (md_done),
    .res_hi   (md_hi),
    .res_lo   (md_lo)
  );

  // Every accept wipes the previous result and flags; iterative ops fill them in on their last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_result <= '0;
      ALU_hi     <= '0;
      ALU_Carry  <= 1'b0;
      Div_zero   <= 1'b0;
      Illegal    <= 1'b0;
      b_zero_q   <= 1'b0;
    end else if (accept) begin
      ALU_result <= simple_res;
      ALU_hi     <= '0;
      ALU_Carry  <= simple_carry;
      Div_zero   <= 1'b0;
      Illegal    <= illegal_op;
      b_zero_q   <= (Src2 == '0);
    end else if (md_done) begin
      ALU_result <= md_lo;
      ALU_hi     <= md_hi;
      Div_zero   <= (state == DIV) && b_zero_q;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver queues hand-computed results on accept,
// a monitor checks each result and its latency when the consumer takes it.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Src1, Src2;
  logic [5:0]  Funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_result, ALU_hi;
  logic        ALU_Carry, Div_zero, Illegal;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        carry;
    logic        dz;
    logic        ill;
    int          lat;
    int          acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   cycle   = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  multicycle_alu #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Src1       (Src1),
    .Src2       (Src2),
    .Funct      (Funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_result (ALU_result),
    .ALU_hi     (ALU_hi),
    .ALU_Carry  (ALU_Carry),
    .Div_zero   (Div_zero),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", what, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic applyStimulus(input string name, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res, input logic [31:0] hi,
                               input logic carry, input logic dz, input logic ill,
                               output int acc_cycle);
    exp_t e;
    int   waited;
    bit   got;
    waited    = 0;
    got       = 1'b0;
    acc_cycle = -1;
    in_valid  = 1'b1;
    Src1      = a;
    Src2      = b;
    Funct     = f;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else          waited++;
    end
    if (!got) begin
      checkOutput({name, " accept timeout"}, 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    acc_cycle   = cycle;
    e.name      = name;
    e.res       = res;
    e.hi        = hi;
    e.carry     = carry;
    e.dz        = dz;
    e.ill       = ill;
    e.lat       = (f == 6'b011000 || f == 6'b011010) ? 32 : 0;
    e.acc_cycle = cycle;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) checkOutput("drain timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: latency on first sight of a result, contents when the consumer takes it
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected out_valid", 32'd1, 32'd0);
        end else begin
          if (!started) begin
            started = 1'b1;
            checkOutput({sb[0].name, " latency"}, 32'(cycle - sb[0].acc_cycle), 32'(sb[0].lat));
          end
          if (out_ready) begin
            checkOutput({sb[0].name, " result"}, ALU_result, sb[0].res);
            checkOutput({sb[0].name, " hi"}, ALU_hi, sb[0].hi);
            checkOutput({sb[0].name, " carry"}, 32'(ALU_Carry), 32'(sb[0].carry));
            checkOutput({sb[0].name, " div_zero"}, 32'(Div_zero), 32'(sb[0].dz));
            checkOutput({sb[0].name, " illegal"}, 32'(Illegal), 32'(sb[0].ill));
            void'(sb.pop_front());
            started = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ac, start_cycle, seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Src1      = '0;
    Src2      = '0;
    Funct     = '0;

    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", ALU_result, 32'd0);
    checkOutput("reset hi", ALU_hi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

    $display("[TB] simple ops, back to back");
    applyStimulus("ADD wrap", 6'b000000, 32'hFFFF_FFFF, 32'h1,        32'h0,         0, 1'b1, 1'b0, 1'b0, ac);
    applyStimulus("SUB borrow", 6'b000001, 32'h10,      32'h20,       32'hFFFF_FFF0, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("SUB noborrow", 6'b000001, 32'h5,     32'h3,        32'h2,         0, 1'b1, 1'b0, 1'b0, ac);
    applyStimulus("AND", 6'b000010, 32'hF0F0_1234, 32'h0FF0_FF00,     32'h00F0_1200, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("OR",  6'b000011, 32'hF000_0000, 32'h0000_000F,     32'hF000_000F, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("XOR", 6'b000100, 32'hFFFF_0000, 32'h0F0F_0F0F,     32'hF0F0_0F0F, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("NOR", 6'b000101, 32'h0,         32'hFFFF_0000,     32'h0000_FFFF, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("SLTU", 6'b000111, 32'hFFFF_FFFF, 32'h1,            32'h0,         0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("SLL shamt", 6'b001000, 32'h1,    32'h24,           32'h10,        0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("SRL", 6'b001001, 32'h8000_0000, 32'h4,             32'h0800_0000, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("SRA", 6'b001010, 32'h8000_0000, 32'h4,             32'hF800_0000, 0, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("ILLEGAL 3F", 6'b111111, 32'h1234, 32'h5678,        32'h0,         0, 1'b0, 1'b0, 1'b1, ac);
    applyStimulus("ILLEGAL 0B", 6'b001011, 32'hFFFF_FFFF, 32'h1,      32'h0,         0, 1'b0, 1'b0, 1'b1, ac);

    $display("[TB] iterative multiply and divide");
    applyStimulus("MULTU max", 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, ac);
    applyStimulus("MULTU small", 6'b011000, 32'h0001_2345, 32'h100,   32'h0123_4500, 32'h0,        1'b0, 1'b0, 1'b0, ac);
    applyStimulus("DIVU exact", 6'b011010, 32'h1800, 32'h200,         32'hC,         32'h0,        1'b0, 1'b0, 1'b0, ac);
    applyStimulus("DIVU rem", 6'b011010, 32'd100, 32'd7,              32'd14,        32'd2,        1'b0, 1'b0, 1'b0, ac);
    applyStimulus("DIVU by0", 6'b011010, 32'h7, 32'h0,                32'hFFFF_FFFF, 32'h7,        1'b0, 1'b1, 1'b0, ac);
    applyStimulus("ADD after div", 6'b000000, 32'h7, 32'h8,           32'hF,         32'h0,        1'b0, 1'b0, 1'b0, ac);
    waitIdle();

    $display("[TB] backpressure and same-edge handoff");
    out_ready = 1'b0;
    applyStimulus("SLT stalled", 6'b000110, 32'hFFFF_FFFF, 32'h1,     32'h1,         32'h0,        1'b0, 1'b0, 1'b0, ac);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall result", ALU_result, 32'h1);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready   = 1'b1;
    start_cycle = cycle;
    applyStimulus("ADD handoff", 6'b000000, 32'h2, 32'h3,             32'h5,         32'h0,        1'b0, 1'b0, 1'b0, ac);
    checkOutput("handoff accept edge", 32'(ac - start_cycle), 32'd1);
    waitIdle();

    $display("[TB] reset during MULTU");
    applyStimulus("MULTU aborted", 6'b011000, 32'h1234_5678, 32'h9,   32'h0,         32'h0,        1'b0, 1'b0, 1'b0, ac);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort result", ALU_result, 32'd0);
    checkOutput("abort hi", ALU_hi, 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("post-abort out_valid cycles", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus("ADD recovery", 6'b000000, 32'h8000_0000, 32'h8000_0000, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, ac);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
